// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//
// Decode-stage instruction queue for the MIPS pipeline. Each fetched
// instruction is decoded into the main-control bundle and a reserved-
// instruction flag as it is written. The instruction, its PC and the decode
// result are held together in a circular buffer of DEPTH entries. The oldest
// entry is presented to the ID/EX consumer. Fetch stalls and execute stalls
// are therefore independent of each other.
//
// Parameters
//   DEPTH        number of entries (power of two, >= 2)
//   PC_W         PC width
//
// Ports
//   clk          clock, all state updates on the rising edge
//   resetn       synchronous active-low reset
//   flush        synchronous queue clear (mispredict / exception)
//   in_valid     fetch offers in_instr / in_pc
//   in_ready     queue can accept (not full, not in reset)
//   in_instr     instruction word
//   in_pc        instruction PC
//   out_valid    head entry present
//   out_ready    consumer takes the head entry
//   out_instr    head instruction
//   out_pc       head PC
//   out_ctrl     {branch,jump,jal,jr,bal,aluSrc,memRead,memWrite,
//                 memToReg,regWrite,regDst} of the head, 0 when empty
//   out_invalid  head is a reserved instruction, 0 when empty
//   count        current occupancy
// -----------------------------------------------------------------------------
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [PC_W-1:0]          out_pc,
   output logic [10:0]              out_ctrl,
   output logic                     out_invalid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Control bundle bit positions
   localparam logic [10:0] C_BRANCH   = 11'b100_0000_0000;
   localparam logic [10:0] C_JUMP     = 11'b010_0000_0000;
   localparam logic [10:0] C_JAL      = 11'b001_0000_0000;
   localparam logic [10:0] C_JR       = 11'b000_1000_0000;
   localparam logic [10:0] C_BAL      = 11'b000_0100_0000;
   localparam logic [10:0] C_ALUSRC   = 11'b000_0010_0000;
   localparam logic [10:0] C_MEMREAD  = 11'b000_0001_0000;
   localparam logic [10:0] C_MEMWRITE = 11'b000_0000_1000;
   localparam logic [10:0] C_MEMTOREG = 11'b000_0000_0100;
   localparam logic [10:0] C_REGWRITE = 11'b000_0000_0010;
   localparam logic [10:0] C_REGDST   = 11'b000_0000_0001;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_REGIMM   = 6'b000001;
   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BNE      = 6'b000101;
   localparam logic [5:0] OP_BLEZ     = 6'b000110;
   localparam logic [5:0] OP_BGTZ     = 6'b000111;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_SLTIU    = 6'b001011;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_XORI     = 6'b001110;
   localparam logic [5:0] OP_LUI      = 6'b001111;
   localparam logic [5:0] OP_COP0     = 6'b010000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_LB       = 6'b100000;
   localparam logic [5:0] OP_LH       = 6'b100001;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_LBU      = 6'b100100;
   localparam logic [5:0] OP_LHU      = 6'b100101;
   localparam logic [5:0] OP_SB       = 6'b101000;
   localparam logic [5:0] OP_SH       = 6'b101001;
   localparam logic [5:0] OP_SW       = 6'b101011;

   // SPECIAL function codes
   localparam logic [5:0] F_SLL     = 6'h00;
   localparam logic [5:0] F_SRL     = 6'h02;
   localparam logic [5:0] F_SRA     = 6'h03;
   localparam logic [5:0] F_SLLV    = 6'h04;
   localparam logic [5:0] F_SRLV    = 6'h06;
   localparam logic [5:0] F_SRAV    = 6'h07;
   localparam logic [5:0] F_JR      = 6'h08;
   localparam logic [5:0] F_JALR    = 6'h09;
   localparam logic [5:0] F_SYSCALL = 6'h0C;
   localparam logic [5:0] F_BREAK   = 6'h0D;
   localparam logic [5:0] F_MFHI    = 6'h10;
   localparam logic [5:0] F_MTHI    = 6'h11;
   localparam logic [5:0] F_MFLO    = 6'h12;
   localparam logic [5:0] F_MTLO    = 6'h13;
   localparam logic [5:0] F_MULT    = 6'h18;
   localparam logic [5:0] F_MULTU   = 6'h19;
   localparam logic [5:0] F_DIV     = 6'h1A;
   localparam logic [5:0] F_DIVU    = 6'h1B;
   localparam logic [5:0] F_ADD     = 6'h20;
   localparam logic [5:0] F_ADDU    = 6'h21;
   localparam logic [5:0] F_SUB     = 6'h22;
   localparam logic [5:0] F_SUBU    = 6'h23;
   localparam logic [5:0] F_AND     = 6'h24;
   localparam logic [5:0] F_OR      = 6'h25;
   localparam logic [5:0] F_XOR     = 6'h26;
   localparam logic [5:0] F_NOR     = 6'h27;
   localparam logic [5:0] F_SLT     = 6'h2A;
   localparam logic [5:0] F_SLTU    = 6'h2B;

   // REGIMM rt codes and COP0 rs codes
   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;
   localparam logic [4:0] RS_MFC0   = 5'b00000;
   localparam logic [4:0] RS_MTC0   = 5'b00100;

   localparam logic [31:0] ERET = 32'h4200_0018;

   // Returns {invalid, ctrl[10:0]} for one instruction word.
   function automatic logic [11:0] decode(input logic [31:0] instr);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [10:0] c;
      logic        inv;
      op  = instr[31:26];
      rs  = instr[25:21];
      rt  = instr[20:16];
      fn  = instr[5:0];
      c   = '0;
      inv = 1'b0;
      case (op)
         OP_SPECIAL: begin
            case (fn)
               F_AND, F_OR, F_XOR, F_NOR, F_SLL, F_SRL, F_SRA, F_SLLV,
               F_SRLV, F_SRAV, F_MFHI, F_MFLO, F_ADD, F_ADDU, F_SUB,
               F_SUBU, F_SLT, F_SLTU:
                  c = C_REGWRITE | C_REGDST;
               F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, F_BREAK,
               F_SYSCALL:
                  c = '0;
               F_JR:    c = C_JUMP | C_JR;
               F_JALR:  c = C_JR | C_REGWRITE | C_REGDST;
               default: inv = 1'b1;
            endcase
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_ADDI, OP_ADDIU, OP_SLTI,
         OP_SLTIU:
            c = C_ALUSRC | C_REGWRITE;
         OP_J:   c = C_JUMP;
         OP_JAL: c = C_JAL | C_REGWRITE;
         OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ:
            c = C_BRANCH;
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ, RT_BGEZ:     c = C_BRANCH;
               RT_BLTZAL, RT_BGEZAL: c = C_BRANCH | C_BAL | C_REGWRITE;
               default:              inv = 1'b1;
            endcase
         end
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:
            c = C_ALUSRC | C_MEMREAD | C_MEMTOREG | C_REGWRITE;
         OP_SB, OP_SH, OP_SW:
            c = C_ALUSRC | C_MEMWRITE;
         OP_COP0: begin
            case (rs)
               RS_MTC0: c = '0;
               RS_MFC0: c = C_REGWRITE;
               // eret is the only other COP0 form this core supports
               default: inv = (instr != ERET);
            endcase
         end
         OP_SPECIAL2: c = C_REGWRITE | C_REGDST;
         default:     inv = 1'b1;
      endcase
      return {inv, c};
   endfunction

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          full;
   logic          push;
   logic          pop;
   logic [11:0]   dec_p0;

   logic [31:0]     ent_instr_p1 [DEPTH];
   logic [PC_W-1:0] ent_pc_p1    [DEPTH];
   logic [10:0]     ent_ctrl_p1  [DEPTH];
   logic            ent_inv_p1   [DEPTH];

   // ---- stage 0: handshake and decode of the offered instruction ----
   assign full     = (cnt == FULL_CNT);
   // No full-bypass: a full queue refuses input even while it is draining.
   assign in_ready = !full && resetn;
   assign out_valid = (cnt != '0);
   assign push     = in_valid && in_ready && !flush;
   assign pop      = out_valid && out_ready && !flush;
   assign dec_p0   = decode(in_instr);

   // ---- stage 1: entry storage (data path, not reset) ----
   always_ff @(posedge clk) begin
      if (push) begin
         ent_instr_p1[wr_ptr] <= in_instr;
         ent_pc_p1[wr_ptr]    <= in_pc;
         ent_ctrl_p1[wr_ptr]  <= dec_p0[10:0];
         ent_inv_p1[wr_ptr]   <= dec_p0[11];
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // ---- head presentation, decode fields gated when empty ----
   assign out_instr   = ent_instr_p1[rd_ptr];
   assign out_pc      = ent_pc_p1[rd_ptr];
   assign out_ctrl    = out_valid ? ent_ctrl_p1[rd_ptr] : '0;
   assign out_invalid = out_valid && ent_inv_p1[rd_ptr];
   assign count       = cnt;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;

   logic              clk;
   logic              resetn;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [PC_W-1:0]   out_pc;
   logic [10:0]       out_ctrl;
   logic              out_invalid;
   logic [2:0]        count;

   decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_ctrl(out_ctrl), .out_invalid(out_invalid), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [10:0] ctrl;
      logic        inv;
   } ent_t;

   ent_t        sb[$];
   int          mcnt = 0;
   int          ncmp = 0;
   int          nerr = 0;
   logic        acc  = 1'b0;
   logic [10:0] exp_ctrl = '0;
   logic        exp_inv  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected-response producer: pushes a scoreboard entry whenever the
   // bench's own occupancy model says an offered instruction is taken.
   always @(posedge clk) begin
      acc = 1'b0;
      if (!resetn || flush) begin
         sb.delete();
         mcnt = 0;
      end else begin
         if (in_valid && mcnt < DEPTH) begin
            sb.push_back('{in_instr, in_pc, exp_ctrl, exp_inv});
            acc  = 1'b1;
            mcnt = mcnt + 1;
         end
         if (out_ready && (mcnt - int'(acc)) > 0) mcnt = mcnt - 1;
      end
   end

   // Monitor: compares what the DUT presents against the scoreboard head.
   always @(negedge clk) begin
      chk("count", 32'(count), 32'(mcnt));
      chk("in_ready", 32'(in_ready), 32'(resetn && mcnt < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
      if (mcnt != 0 && sb.size() > 0) begin
         chk("out_instr", out_instr, sb[0].instr);
         chk("out_pc", out_pc, sb[0].pc);
         chk("out_ctrl", 32'(out_ctrl), 32'(sb[0].ctrl));
         chk("out_invalid", 32'(out_invalid), 32'(sb[0].inv));
         if (out_ready && !flush && resetn) void'(sb.pop_front());
      end else if (mcnt == 0) begin
         chk("empty_ctrl", 32'(out_ctrl), 32'h0);
         chk("empty_invalid", 32'(out_invalid), 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] i, input logic [31:0] pc,
                          input logic [10:0] c, input logic inv);
      in_valid = 1'b1;
      in_instr = i;
      in_pc    = pc;
      exp_ctrl = c;
      exp_inv  = inv;
   endtask

   // Hold an instruction until accepted, bounded.
   task automatic send(input logic [31:0] i, input logic [31:0] pc,
                       input logic [10:0] c, input logic inv);
      bit done;
      done = 1'b0;
      present(i, pc, c, inv);
      for (int k = 0; k < 20 && !done; k++) begin
         step();
         done = acc;
      end
      if (!done) begin
         ncmp++;
         nerr++;
         $display("FAIL accept_timeout: instr %h not taken", i);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 20 && mcnt != 0; k++) step();
      chk("drain_empty", 32'(mcnt), 32'h0);
      out_ready = 1'b0;
   endtask

   logic [31:0] s_instr [10] = '{32'h03E00008, 32'h0040F809, 32'h04100004, 32'h34420001,
                                 32'h80820000, 32'h0000000D, 32'h00000001, 32'h40026000,
                                 32'h70851002, 32'h08000010};
   logic [10:0] s_ctrl  [10] = '{11'b01010000000, 11'b00010000011, 11'b10001000010,
                                 11'b00000100010, 11'b00000110110, 11'b00000000000,
                                 11'b00000000000, 11'b00000000010, 11'b00000000011,
                                 11'b01000000000};
   logic        s_inv   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      step(); step();
      chk("reset_count", 32'(count), 32'h0);
      chk("reset_in_ready", 32'(in_ready), 32'h0);
      resetn = 1'b1;
      #1;
      chk("release_in_ready", 32'(in_ready), 32'h1);

      // single addu
      present(32'h00851021, 32'h100, 11'b00000000011, 1'b0);
      step();
      in_valid = 1'b0;
      chk("addu_valid", 32'(out_valid), 32'h1);
      chk("addu_ctrl", 32'(out_ctrl), 32'(11'b00000000011));
      chk("addu_count", 32'(count), 32'h1);
      step();
      drain();

      // fill: lw, sw, beq, jal
      send(32'h8C820004, 32'h200, 11'b00000110110, 1'b0);
      send(32'hAC820008, 32'h204, 11'b00000101000, 1'b0);
      send(32'h10850003, 32'h208, 11'b10000000000, 1'b0);
      send(32'h0C000040, 32'h20C, 11'b00100000010, 1'b0);
      chk("full_count", 32'(count), 32'h4);
      chk("full_in_ready", 32'(in_ready), 32'h0);
      present(32'h24420001, 32'h210, 11'b00000100010, 1'b0);
      step();
      chk("fifth_refused", 32'(acc), 32'h0);
      chk("fifth_count", 32'(count), 32'h4);

      // full with out_ready: dequeue only first, then 1-in/1-out
      out_ready = 1'b1;
      present(s_instr[0], 32'h300, s_ctrl[0], s_inv[0]);
      step();
      chk("full_deq_only", 32'(count), 32'h3);
      chk("full_deq_no_acc", 32'(acc), 32'h0);
      for (int n = 0; n < 10; n++) begin
         present(s_instr[n], 32'h300 + 32'(n * 4), s_ctrl[n], s_inv[n]);
         step();
         chk("stream_acc", 32'(acc), 32'h1);
         chk("stream_count", 32'(count), 32'h3);
      end
      in_valid = 1'b0;
      drain();

      // reserved / boundary decodes
      send(32'hFC000000, 32'h400, 11'b0, 1'b1);
      send(32'h42000018, 32'h404, 11'b0, 1'b0);
      send(32'h42000019, 32'h408, 11'b0, 1'b1);
      send(32'h04020000, 32'h40C, 11'b0, 1'b1);
      drain();
      send(32'hA0820000, 32'h410, 11'b00000101000, 1'b0);
      send(32'h40826000, 32'h414, 11'b0, 1'b0);
      send(32'h0000000C, 32'h418, 11'b0, 1'b0);
      drain();

      // flush with count=3 and a concurrent offer
      send(32'h00851021, 32'h500, 11'b00000000011, 1'b0);
      send(32'h8C820004, 32'h504, 11'b00000110110, 1'b0);
      send(32'hAC820008, 32'h508, 11'b00000101000, 1'b0);
      chk("preflush_count", 32'(count), 32'h3);
      flush = 1'b1;
      present(32'h10850003, 32'h50C, 11'b10000000000, 1'b0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", 32'(count), 32'h0);
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_ctrl", 32'(out_ctrl), 32'h0);
      step();

      // reset mid-stream with count=2
      send(32'h34420001, 32'h600, 11'b00000100010, 1'b0);
      send(32'h08000010, 32'h604, 11'b01000000000, 1'b0);
      chk("prereset_count", 32'(count), 32'h2);
      resetn = 1'b0;
      present(32'h00851021, 32'h608, 11'b00000000011, 1'b0);
      #1;
      chk("inreset_in_ready", 32'(in_ready), 32'h0);
      step();
      chk("midreset_count", 32'(count), 32'h0);
      chk("midreset_valid", 32'(out_valid), 32'h0);
      resetn = 1'b1; in_valid = 1'b0;
      #1;
      chk("after_release_in_ready", 32'(in_ready), 32'h1);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode-stage instruction queue for the MIPS pipeline. Accepts fetched instructions (with PC) over a valid/ready handshake, decodes each one into the 11-bit main-control bundle plus a reserved-instruction flag at enqueue time, and stores the results in a circular buffer of DEPTH entries. It presents the oldest entry to the ID/EX consumer over a second valid/ready handshake. It replaces the purely combinational decode path and decouples fetch stalls from execute stalls.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- PC_W, 32: PC width.

- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- flush  in  1  synchronous queue clear (branch mispredict or exception).
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept; equals !full && resetn.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes head.
- out_instr  out  32  head instruction.
- out_pc  out  PC_W  head PC.
- out_ctrl  out  11  {branch,jump,jal,jr,bal,aluSrc,memRead,memWrite,memToReg,regWrite,regDst}.
- out_invalid  out  1  head is a reserved instruction.
- count  out  clog2(DEPTH)+1  current occupancy.

## Operation
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready. Pointers wrap modulo DEPTH. count updates by +1, -1, or 0 (both in the same cycle).
- When full, in_ready=0 even if a dequeue occurs in the same cycle; there is no full-bypass.
- Decode is combinational on in_instr and is written into the entry together with the instruction and PC. Output fields are read from head storage.
- Decode table (ctrl bits named; all others 0; invalid=0 unless stated):
  - SPECIAL: and/or/xor/nor/sll/srl/sra/sllv/srlv/srav/mfhi/mflo/add/addu/sub/subu/slt/sltu → regWrite,regDst.
  - SPECIAL: mthi/mtlo/mult/multu/div/divu/break/syscall → none.
  - SPECIAL: jr → jump,jr. jalr → jr,regWrite,regDst. Any other funct → none, invalid=1.
  - andi/ori/xori/lui/addi/addiu/slti/sltiu → aluSrc,regWrite.
  - j → jump. jal → jal,regWrite.
  - beq/bne/bgtz/blez → branch.
  - REGIMM: bltz/bgez → branch. bltzal/bgezal → branch,bal,regWrite. Other rt → invalid=1.
  - lb/lbu/lh/lhu/lw → aluSrc,memRead,memToReg,regWrite. sb/sh/sw → aluSrc,memWrite.
  - COP0: mtc0 → none. mfc0 → regWrite. Other rs → none, with invalid=1 unless instr==32'h42000018 (eret).
  - SPECIAL2 (op 6'b011100) → regWrite,regDst.
  - Any other opcode → none, invalid=1.
- When empty: out_valid=0, and out_ctrl=0, out_invalid=0 (gated). out_instr and out_pc are don't-care.
- flush=1: pointers and count are cleared at the edge. A concurrent enqueue or dequeue is discarded.
- Precedence: resetn low > flush > enqueue/dequeue.

## Timing
- Reset (resetn=0 at an edge): count=0, pointers=0, out_valid=0, out_ctrl=0, out_invalid=0. in_ready=0 while resetn=0, and 1 in the first cycle after release.
- Latency: an instruction enqueued at edge N is visible at the outputs with out_valid=1 after edge N. There is no same-cycle fall-through from in_* to out_*.
- Throughput: 1 enqueue + 1 dequeue per cycle while 0<count<DEPTH.
- in_ready, out_valid, out_* depend only on registered state. They have no combinational path from in_valid/out_ready.
- Reset or flush mid-stream: all entries are lost and the next cycle is empty. Fetch must re-present any instruction it wants queued.
- Wrap: after DEPTH enqueues the write pointer returns to 0, and ordering is preserved across the wrap.

## Test plan
- Reset then single addu (32'h00851021) enqueue, out_ready=0 → next cycle out_valid=1, out_ctrl=11'b00000000011, count=1, out_invalid=0.
- Enqueue lw, sw, beq, jal, with out_ready=0 and DEPTH=4 → after 4 cycles count=4 and in_ready=0; ctrl in order is 00000110110, 00000101000, 10000000000, 00100000010. A 5th in_valid is not accepted.
- Full queue with out_ready=1 and in_valid=1 → first cycle dequeue only (count=3); the following cycles run sustained 1-in/1-out with count steady at 3. Run 10 instructions to check FIFO order across the pointer wrap.
- Reserved cases: op 6'b111111 → invalid=1, ctrl=0; COP0 32'h42000018 → invalid=0; COP0 32'h42000019 → invalid=1; REGIMM rt=5'b00010 → invalid=1.
- flush asserted with count=3 together with in_valid=1 → next cycle count=0, out_valid=0, out_ctrl=0.
- resetn low for one cycle mid-stream with count=2 → next cycle count=0, in_ready=0 during reset and 1 after release.
